npu_sram_port_arbiter: RTL and testbench

//  Round-robin arbiter that shares one port of a 16-bit x 4096 dual-port on-chip SRAM between NUM_REQ Avalon-MM-style masters.

---
 rtl/npu_sram_pkg.sv | 18 +
 rtl/npu_sram_port_arbiter_if.sv | 26 ++
 rtl/npu_rr_pick.sv | 30 +++
 rtl/npu_sram_port_arbiter.sv | 126 ++++++++++++
 tb/tb_npu_sram_port_arbiter.sv | 370 +++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/npu_sram_pkg.sv
// Shared types and sizes for the NPU on-chip SRAM port arbiter.
package npu_sram_pkg;

  localparam int NUM_REQ_DEF = 4;
  localparam int ADDR_W      = 12;
  localparam int DATA_W      = 16;
  localparam int BE_W        = DATA_W / 8;

  typedef logic [$clog2(NUM_REQ_DEF)-1:0] req_id_t;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [BE_W-1:0]   be;
    logic [DATA_W-1:0] wdata;
    logic              write;
  } sram_cmd_t;

endpackage

// File: rtl/npu_sram_port_arbiter_if.sv
// Requester-side bus of the SRAM port arbiter: packed per-requester Avalon-MM style signals.
interface npu_sram_port_arbiter_if
  import npu_sram_pkg::*;
#(
  parameter int NUM_REQ = NUM_REQ_DEF
);
  logic [NUM_REQ-1:0]        req_read;
  logic [NUM_REQ-1:0]        req_write;
  logic [NUM_REQ-1:0]        req_lock;
  logic [NUM_REQ*ADDR_W-1:0] req_address;
  logic [NUM_REQ*DATA_W-1:0] req_writedata;
  logic [NUM_REQ*BE_W-1:0]   req_byteenable;
  logic [NUM_REQ-1:0]        req_waitrequest;
  logic [DATA_W-1:0]         req_readdata;
  logic [NUM_REQ-1:0]        req_readdatavalid;

  modport master (
    output req_read, req_write, req_lock, req_address, req_writedata, req_byteenable,
    input  req_waitrequest, req_readdata, req_readdatavalid
  );

  modport slave (
    input  req_read, req_write, req_lock, req_address, req_writedata, req_byteenable,
    output req_waitrequest, req_readdata, req_readdatavalid
  );
endinterface

// File: rtl/npu_rr_pick.sv
// Combinational round-robin pick: first set bit of pending searching upward from ptr+1.
module npu_rr_pick #(
  parameter  int N  = 4,
  localparam int IW = $clog2(N)
) (
  input  logic [N-1:0]  pending,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] idx,
  output logic          any
);

  logic [IW-1:0] j;

  always_comb begin
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    j     = '0;
    for (int k = 1; k <= N; k++) begin
      j = IW'((int'(ptr) + k) % N);
      if (!any && pending[j]) begin
        any      = 1'b1;
        grant[j] = 1'b1;
        idx      = j;
      end
    end
  end

endmodule

// File: rtl/npu_sram_port_arbiter.sv
// Round-robin arbiter sharing one SRAM port between NUM_REQ masters, one transfer per clock.
// Optional macro SRAM_ARB_LOCK_EN lets an accepted winner hold the port through req_lock.
module npu_sram_port_arbiter
  import npu_sram_pkg::*;
#(
  parameter int NUM_REQ = NUM_REQ_DEF
) (
  input  logic                   clk,
  input  logic                   reset_n,
  npu_sram_port_arbiter_if.slave req,
  output logic [ADDR_W-1:0]      sram_address,
  output logic [BE_W-1:0]        sram_byteenable,
  output logic                   sram_chipselect,
  output logic                   sram_write,
  output logic [DATA_W-1:0]      sram_writedata,
  input  logic [DATA_W-1:0]      sram_readdata
);

  localparam int ID_W = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0] pending;
  logic [NUM_REQ-1:0] eligible;
  logic [NUM_REQ-1:0] grant;
  logic [NUM_REQ-1:0] rdv;
  logic [ID_W-1:0]    ptr;
  logic [ID_W-1:0]    win_id;
  logic               win_any;
  sram_cmd_t          win_cmd;
  sram_cmd_t          cmd_q;
  logic               rd_v1, rd_v2;
  logic [ID_W-1:0]    rd_id1, rd_id2;

  assign pending = req.req_read | req.req_write;

`ifdef SRAM_ARB_LOCK_EN
  logic            lock_q;
  logic [ID_W-1:0] lock_id;

  // A lock holder that stops requesting releases the port in the same cycle.
  always_comb begin
    eligible = pending;
    if (lock_q && pending[lock_id]) begin
      eligible          = '0;
      eligible[lock_id] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      lock_q  <= 1'b0;
      lock_id <= '0;
    end else if (win_any) begin
      lock_q  <= req.req_lock[win_id];
      lock_id <= win_id;
    end else begin
      lock_q  <= 1'b0;
    end
  end
`else
  logic unused_lock;
  assign unused_lock = ^req.req_lock;
  assign eligible    = pending;
`endif

  npu_rr_pick #(.N(NUM_REQ)) u_pick (
    .pending (eligible),
    .ptr     (ptr),
    .grant   (grant),
    .idx     (win_id),
    .any     (win_any)
  );

  always_comb begin
    win_cmd.addr  = req.req_address[int'(win_id)*ADDR_W +: ADDR_W];
    win_cmd.be    = req.req_byteenable[int'(win_id)*BE_W +: BE_W];
    win_cmd.wdata = req.req_writedata[int'(win_id)*DATA_W +: DATA_W];
    win_cmd.write = req.req_write[win_id];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ptr             <= ID_W'(NUM_REQ - 1);
      cmd_q           <= '0;
      sram_chipselect <= 1'b0;
    end else if (win_any) begin
      ptr             <= win_id;
      cmd_q           <= win_cmd;
      sram_chipselect <= 1'b1;
    end else begin
      cmd_q.write     <= 1'b0;
      sram_chipselect <= 1'b0;
    end
  end

  // Stage 1 follows the command register, stage 2 lines up with the SRAM's registered output.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_v1  <= 1'b0;
      rd_v2  <= 1'b0;
      rd_id1 <= '0;
      rd_id2 <= '0;
    end else begin
      rd_v1  <= win_any && !win_cmd.write;
      rd_id1 <= win_id;
      rd_v2  <= rd_v1;
      rd_id2 <= rd_id1;
    end
  end

  always_comb begin
    rdv = '0;
    if (rd_v2) rdv[rd_id2] = 1'b1;
  end

  assign sram_address          = cmd_q.addr;
  assign sram_byteenable       = cmd_q.be;
  assign sram_writedata        = cmd_q.wdata;
  assign sram_write            = cmd_q.write;
  assign req.req_waitrequest   = reset_n ? ~grant : '1;
  assign req.req_readdata      = reset_n ? sram_readdata : '0;
  assign req.req_readdatavalid = rdv;

  rw_conflict: assert property (@(posedge clk) disable iff (!reset_n)
    (req.req_read & req.req_write) == '0);

endmodule

// File: tb/tb_npu_sram_port_arbiter.sv
// Bench for npu_sram_port_arbiter: directed scenarios plus random traffic against a transaction-level model.
module tb_npu_sram_port_arbiter;
  import npu_sram_pkg::*;

  localparam int N = 4;

  logic              clk = 1'b0;
  logic              reset_n;
  logic [ADDR_W-1:0] sram_address;
  logic [BE_W-1:0]   sram_byteenable;
  logic              sram_chipselect;
  logic              sram_write;
  logic [DATA_W-1:0] sram_writedata;
  logic [DATA_W-1:0] sram_readdata;

  int checks   = 0;
  int failures = 0;

  npu_sram_port_arbiter_if #(.NUM_REQ(N)) bus ();

  npu_sram_port_arbiter #(.NUM_REQ(N)) dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .req             (bus.slave),
    .sram_address    (sram_address),
    .sram_byteenable (sram_byteenable),
    .sram_chipselect (sram_chipselect),
    .sram_write      (sram_write),
    .sram_writedata  (sram_writedata),
    .sram_readdata   (sram_readdata)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] init_val(input int a);
    if (a == 0)     return 16'h0F0F;
    if (a == 'h010) return 16'h1234;
    if (a == 'h0FF) return 16'hAAAA;
    return 16'((a * 40503) ^ 16'h5A5A);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Synchronous single-port SRAM with registered read output.
  logic [15:0] mem [4096];
  logic [15:0] rdata_q;
  assign sram_readdata = rdata_q;

  initial begin
    rdata_q = '0;
    for (int i = 0; i < 4096; i++) mem[i] = init_val(i);
    forever begin
      @(posedge clk);
      if (sram_chipselect) begin
        if (sram_write) begin
          for (int b = 0; b < BE_W; b++)
            if (sram_byteenable[b]) mem[sram_address][b*8 +: 8] = sram_writedata[b*8 +: 8];
        end else begin
          rdata_q <= mem[sram_address];
        end
      end
    end
  end

  // Transaction-level model: who wins now, what the port shows next cycle, which read returns when.
  logic [15:0]       shadow [4096];
  int                m_ptr;
  logic              e_cs, e_write;
  logic [11:0]       e_addr;
  logic [1:0]        e_be;
  logic [15:0]       e_wd;
  int                sched_id [int];
  logic [15:0]       sched_data [int];
`ifdef SRAM_ARB_LOCK_EN
  logic              m_lock;
  int                m_lock_id;
`endif

  initial begin
    int          cyc;
    int          win;
    logic [N-1:0] pend, elig, exp_wait, exp_rdv;
    logic [11:0] a;
    cyc = 0;
    m_ptr = N - 1;
    e_cs = 0; e_write = 0; e_addr = '0; e_be = '0; e_wd = '0;
`ifdef SRAM_ARB_LOCK_EN
    m_lock = 0; m_lock_id = 0;
`endif
    for (int i = 0; i < 4096; i++) shadow[i] = init_val(i);
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        chk("rst_waitrequest", 32'(bus.req_waitrequest), 32'hF);
        chk("rst_rdv", 32'(bus.req_readdatavalid), 32'h0);
        chk("rst_readdata", 32'(bus.req_readdata), 32'h0);
        chk("rst_cs", 32'(sram_chipselect), 32'h0);
        chk("rst_write", 32'(sram_write), 32'h0);
        chk("rst_addr", 32'(sram_address), 32'h0);
        chk("rst_be", 32'(sram_byteenable), 32'h0);
        chk("rst_wdata", 32'(sram_writedata), 32'h0);
        m_ptr = N - 1;
        e_cs = 0; e_write = 0;
`ifdef SRAM_ARB_LOCK_EN
        m_lock = 0;
`endif
        sched_id.delete();
        sched_data.delete();
      end else begin
        pend = bus.req_read | bus.req_write;
        elig = pend;
`ifdef SRAM_ARB_LOCK_EN
        if (m_lock && pend[m_lock_id]) begin
          elig = '0;
          elig[m_lock_id] = 1'b1;
        end
`endif
        win = -1;
        for (int k = 1; k <= N; k++)
          if (win < 0 && elig[(m_ptr + k) % N]) win = (m_ptr + k) % N;
        exp_wait = '1;
        if (win >= 0) exp_wait[win] = 1'b0;
        chk("waitrequest", 32'(bus.req_waitrequest), 32'(exp_wait));
        chk("chipselect", 32'(sram_chipselect), 32'(e_cs));
        if (e_cs) begin
          chk("sram_address", 32'(sram_address), 32'(e_addr));
          chk("sram_be", 32'(sram_byteenable), 32'(e_be));
          chk("sram_write", 32'(sram_write), 32'(e_write));
          if (e_write) chk("sram_wdata", 32'(sram_writedata), 32'(e_wd));
        end else begin
          chk("sram_write_idle", 32'(sram_write), 32'h0);
        end
        exp_rdv = '0;
        if (sched_id.exists(cyc)) exp_rdv[sched_id[cyc]] = 1'b1;
        chk("readdatavalid", 32'(bus.req_readdatavalid), 32'(exp_rdv));
        if (sched_id.exists(cyc)) begin
          chk("readdata", 32'(bus.req_readdata), 32'(sched_data[cyc]));
          sched_id.delete(cyc);
          sched_data.delete(cyc);
        end
        if (win >= 0) begin
          a       = bus.req_address[win*ADDR_W +: ADDR_W];
          e_cs    = 1;
          e_addr  = a;
          e_be    = bus.req_byteenable[win*BE_W +: BE_W];
          e_wd    = bus.req_writedata[win*DATA_W +: DATA_W];
          e_write = bus.req_write[win];
          if (e_write) begin
            for (int b = 0; b < BE_W; b++)
              if (e_be[b]) shadow[a][b*8 +: 8] = e_wd[b*8 +: 8];
          end else begin
            sched_id[cyc + 2]   = win;
            sched_data[cyc + 2] = shadow[a];
          end
          m_ptr = win;
`ifdef SRAM_ARB_LOCK_EN
          m_lock    = bus.req_lock[win];
          m_lock_id = win;
`endif
        end else begin
          e_cs = 0;
          e_write = 0;
`ifdef SRAM_ARB_LOCK_EN
          m_lock = 0;
`endif
        end
      end
      cyc++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_all();
    bus.req_read       = '0;
    bus.req_write      = '0;
    bus.req_lock       = '0;
    bus.req_address    = '0;
    bus.req_writedata  = '0;
    bus.req_byteenable = '0;
  endtask

  task automatic drive(input int i, input bit rd, input bit wr, input logic [11:0] a,
                       input logic [15:0] d, input logic [1:0] be, input bit lk);
    bus.req_read[i]                          = rd;
    bus.req_write[i]                         = wr;
    bus.req_lock[i]                          = lk;
    bus.req_address[i*ADDR_W +: ADDR_W]      = a;
    bus.req_writedata[i*DATA_W +: DATA_W]    = d;
    bus.req_byteenable[i*BE_W +: BE_W]       = be;
  endtask

  task automatic pulse_reset();
    reset_n = 0;
    idle_all();
    @(negedge clk);
    chk("pulse_rst_wait", 32'(bus.req_waitrequest), 32'hF);
    chk("pulse_rst_cs", 32'(sram_chipselect), 32'h0);
    tick();
    reset_n = 1;
  endtask

  initial begin
    int acc [N];
    int rcnt [N];
    int ones;
    int n3, w;
    int seq [4];
    int exp_seq [4];
    logic [11:0] ra;
    int pick;

    reset_n = 0;
    idle_all();
    repeat (3) @(posedge clk);
    #1;
    reset_n = 1;

    // Single read by requester 1
    drive(1, 1, 0, 12'h010, 16'h0, 2'b11, 0);
    @(negedge clk);
    chk("t1_wait", 32'(bus.req_waitrequest), 32'hD);
    tick();
    idle_all();
    @(negedge clk);
    chk("t1_addr", 32'(sram_address), 32'h010);
    chk("t1_cs", 32'(sram_chipselect), 32'h1);
    tick();
    @(negedge clk);
    chk("t1_rdv", 32'(bus.req_readdatavalid), 32'h2);
    chk("t1_data", 32'(bus.req_readdata), 32'h1234);
    tick();

    // Full contention, 64 cycles
    pulse_reset();
    for (int i = 0; i < N; i++) begin acc[i] = 0; rcnt[i] = 0; end
    ones = 0;
    for (int c = 0; c < 66; c++) begin
      if (c < 64) for (int i = 0; i < N; i++) drive(i, 1, 0, 12'($urandom), 16'h0, 2'b11, 0);
      else idle_all();
      @(negedge clk);
      if (c == 0) chk("t2_first", 32'(bus.req_waitrequest), 32'hE);
      if (c < 64) begin
        if ($countones(~bus.req_waitrequest) == 1) ones++;
        for (int i = 0; i < N; i++) if (!bus.req_waitrequest[i]) acc[i]++;
      end
      for (int i = 0; i < N; i++) if (bus.req_readdatavalid[i]) rcnt[i]++;
      tick();
    end
    chk("t2_no_bubble", 32'(ones), 32'd64);
    for (int i = 0; i < N; i++) begin
      chk("t2_accepts", 32'(acc[i]), 32'd16);
      chk("t2_rdv_count", 32'(rcnt[i]), 32'd16);
    end

    // Write with byte-enable then read back
    drive(2, 0, 1, 12'h0FF, 16'hBEEF, 2'b01, 0);
    tick();
    drive(2, 1, 0, 12'h0FF, 16'h0, 2'b11, 0);
    tick();
    idle_all();
    tick();
    @(negedge clk);
    chk("t3_rdv", 32'(bus.req_readdatavalid), 32'h4);
    chk("t3_data", 32'(bus.req_readdata), 32'hAAEF);
    tick();

    // Reset mid-stream
    drive(0, 1, 0, 12'h100, 16'h0, 2'b11, 0);
    tick();
    idle_all();
    drive(1, 1, 0, 12'h101, 16'h0, 2'b11, 0);
    tick();
    idle_all();
    drive(2, 1, 0, 12'h102, 16'h0, 2'b11, 0);
    tick();
    idle_all();
    reset_n = 0;
    @(negedge clk);
    chk("t4_rdv_in_reset", 32'(bus.req_readdatavalid), 32'h0);
    tick();
    reset_n = 1;
    for (int i = 0; i < N; i++) drive(i, 1, 0, 12'h200 + 12'(i), 16'h0, 2'b11, 0);
    @(negedge clk);
    chk("t4_rdv_after", 32'(bus.req_readdatavalid), 32'h0);
    chk("t4_first_grant", 32'(bus.req_waitrequest), 32'hE);
    tick();
    idle_all();
    @(negedge clk);
    chk("t4_rdv_after2", 32'(bus.req_readdatavalid), 32'h0);
    repeat (3) tick();

    // Lock: requester 3 wants 3 beats while requester 0 is pending
    drive(2, 1, 0, 12'h300, 16'h0, 2'b11, 0);
    tick();
    idle_all();
    n3 = 0;
    for (int c = 0; c < 4; c++) begin
      drive(0, 1, 0, 12'h310, 16'h0, 2'b11, 0);
      drive(3, 1, 0, 12'h320 + 12'(c), 16'h0, 2'b11, n3 < 2);
      @(negedge clk);
      w = -1;
      for (int i = 0; i < N; i++) if (!bus.req_waitrequest[i]) w = i;
      seq[c] = w;
      if (w == 3) n3++;
      tick();
    end
    idle_all();
`ifdef SRAM_ARB_LOCK_EN
    exp_seq = '{3, 3, 3, 0};
`else
    exp_seq = '{3, 0, 3, 0};
`endif
    for (int c = 0; c < 4; c++) chk("t5_order", 32'(seq[c]), 32'(exp_seq[c]));
    repeat (3) tick();

    // Top-of-range address
    drive(0, 0, 1, 12'hFFF, 16'h5A5A, 2'b11, 0);
    tick();
    drive(0, 1, 0, 12'hFFF, 16'h0, 2'b11, 0);
    tick();
    drive(0, 1, 0, 12'h000, 16'h0, 2'b11, 0);
    tick();
    idle_all();
    @(negedge clk);
    chk("t6_rdv", 32'(bus.req_readdatavalid), 32'h1);
    chk("t6_data_fff", 32'(bus.req_readdata), 32'h5A5A);
    tick();
    @(negedge clk);
    chk("t6_data_000", 32'(bus.req_readdata), 32'h0F0F);
    tick();

    // Random traffic with one reset in the middle
    for (int c = 0; c < 400; c++) begin
      if (c == 200) reset_n = 0;
      if (c == 201) reset_n = 1;
      for (int i = 0; i < N; i++) begin
        pick = $urandom_range(0, 4);
        case (pick)
          0:       ra = 12'h000;
          1:       ra = 12'hFFF;
          2:       ra = 12'h0FF;
          3:       ra = 12'h010;
          default: ra = 12'($urandom);
        endcase
        case ($urandom_range(0, 3))
          1:       drive(i, 1, 0, ra, 16'($urandom), 2'($urandom), 1'($urandom));
          2:       drive(i, 0, 1, ra, 16'($urandom), 2'($urandom), 1'($urandom));
          default: drive(i, 0, 0, ra, 16'($urandom), 2'($urandom), 1'($urandom));
        endcase
      end
      tick();
    end
    idle_all();
    repeat (5) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
